tmds_period_sched: RTL and testbench

- Per-pixel period scheduler that sits between the video timing/pixel source and the three TMDS channel encoders, ahead of the 10:1 serializers.
- Inserts the video preamble and leading guard band ahead of every active region.
- Inserts at most one data island per line (preamble, guard bands, 32 TERC4 cycles) during blanking, sourced from a packet requester through a read handshake.
- Tells each encoder which coding mode to apply per pixel, and delays video and sync to match the lookahead.

---
 rtl/tmds_period_sched.sv | 181 ++++++++++++++++++
 tb/tb_tmds_period_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tmds_period_sched.sv
// Per-pixel TMDS period scheduler: looks 10 pixels ahead to insert video preamble/guard
// bands and one data island per line, then emits per-channel coding mode with aligned video.
module tmds_period_sched #(
  parameter int ISL_OFFSET = 4,
  parameter bit HS_POL     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic [23:0] rgb_i,
  input  logic        isl_req_i,
  input  logic [8:0]  isl_d_i,
  output logic        isl_rd_o,
  output logic        isl_done_o,
  output logic        isl_abort_o,
  output logic [2:0]  mode_o,
  output logic [1:0]  sync_o,
  output logic [3:0]  ctl_o,
  output logic [23:0] rgb_o,
  output logic [11:0] terc_o
);
  localparam int         LAT  = 11;
  localparam int         DLY  = LAT - 1;
  localparam logic [6:0] OFFS = 7'(ISL_OFFSET);

  localparam logic [2:0] M_CTRL = 3'd0, M_VGB = 3'd1, M_VID = 3'd2, M_IGB = 3'd3, M_ISL = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGB, S_DATA, S_TGB, S_DONE} state_t;

  // Index k holds pixel n+9-k; the current input is pixel n+10.
  logic [DLY-1:0]       r_de_sr, r_hs_sr, r_vs_sr;
  logic [DLY-1:0][23:0] r_rgb_sr;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_hs_act_d;
  logic [6:0]  r_since;
  logic        r_line_done;

  logic [2:0]  r_mode;
  logic [3:0]  r_ctl;
  logic [1:0]  r_sync;
  logic [23:0] r_rgb;
  logic [11:0] r_terc;
  logic        r_done, r_abort;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_de_sr  <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
      r_rgb_sr <= '0;
    end else begin
      r_de_sr  <= {r_de_sr[DLY-2:0], de_i};
      r_hs_sr  <= {r_hs_sr[DLY-2:0], hs_i};
      r_vs_sr  <= {r_vs_sr[DLY-2:0], vs_i};
      r_rgb_sr <= {r_rgb_sr[DLY-2:0], rgb_i};
    end
  end

  logic        w_de_n, w_hs_n, w_vs_n;
  logic [23:0] w_rgb_n;
  logic        w_hs_act, w_edge;
  logic        w_vid_gb, w_vid_pre, w_de_any;
  logic        w_start, w_abort, w_rd;
  state_t      w_st;
  logic [4:0]  w_cnt;
  logic [2:0]  w_mode;
  logic [3:0]  w_ctl;
  logic [23:0] w_rgb;
  logic [11:0] w_terc;

  assign w_de_n    = r_de_sr[DLY-1];
  assign w_hs_n    = r_hs_sr[DLY-1];
  assign w_vs_n    = r_vs_sr[DLY-1];
  assign w_rgb_n   = r_rgb_sr[DLY-1];
  assign w_hs_act  = (w_hs_n == HS_POL);
  assign w_edge    = w_hs_act && !r_hs_act_d;
  assign w_vid_gb  = r_de_sr[DLY-2] | r_de_sr[DLY-3];
  assign w_vid_pre = (|r_de_sr[DLY-4:0]) | de_i;
  assign w_de_any  = w_de_n | w_vid_gb | w_vid_pre;

  assign w_start = (r_state == S_IDLE) && (r_since == OFFS) && isl_req_i &&
                   !r_line_done && !w_de_any;
  // Upcoming active video cancels an island still in flight; DONE is already complete.
  assign w_abort = (r_state != S_IDLE) && (r_state != S_DONE) && de_i;
  assign w_st    = w_start ? S_PRE : r_state;
  assign w_cnt   = w_start ? 5'd0 : r_cnt;
  assign w_rd    = (w_st == S_DATA) && !w_abort && !rst_i;

  always_comb begin
    w_mode = M_CTRL;
    w_ctl  = 4'b0000;
    w_rgb  = '0;
    w_terc = '0;
    if (w_de_n) begin
      w_mode = M_VID;
      w_rgb  = w_rgb_n;
    end else if (w_vid_gb) begin
      w_mode = M_VGB;
    end else if (w_vid_pre) begin
      w_ctl = 4'b0001;
    end else begin
      case (w_st)
        S_PRE: w_ctl = 4'b0101;
        S_LGB, S_TGB: begin
          w_mode = M_IGB;
          w_terc = {8'h00, 2'b11, w_vs_n, w_hs_n};
        end
        S_DATA: begin
          w_mode = M_ISL;
          w_terc = {isl_d_i[8:5], isl_d_i[4:1], (w_cnt != 5'd0), isl_d_i[0], w_vs_n, w_hs_n};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hs_act_d  <= 1'b1;
      r_since     <= '0;
      r_line_done <= 1'b0;
      r_mode      <= M_CTRL;
      r_ctl       <= '0;
      r_sync      <= '0;
      r_rgb       <= '0;
      r_terc      <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_hs_act_d <= w_hs_act;
      if (w_edge)
        r_since <= 7'd1;
      else if (r_since != 7'd0 && r_since != 7'h7f)
        r_since <= r_since + 7'd1;
      if (w_start)
        r_line_done <= 1'b1;
      else if (w_edge)
        r_line_done <= 1'b0;

      r_state <= w_st;
      r_cnt   <= w_cnt + 5'd1;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (w_st)
          S_PRE:  if (w_cnt == 5'd7)  begin r_state <= S_LGB;  r_cnt <= '0; end
          S_LGB:  if (w_cnt == 5'd1)  begin r_state <= S_DATA; r_cnt <= '0; end
          S_DATA: if (w_cnt == 5'd31) begin r_state <= S_TGB;  r_cnt <= '0; end
          S_TGB:  if (w_cnt == 5'd1)  begin r_state <= S_DONE; r_cnt <= '0; end
          S_DONE: begin r_state <= S_IDLE; r_cnt <= '0; end
          default: r_cnt <= '0;
        endcase
      end

      r_mode  <= w_mode;
      r_ctl   <= w_ctl;
      r_sync  <= {w_vs_n, w_hs_n};
      r_rgb   <= w_rgb;
      r_terc  <= w_terc;
      r_done  <= (w_st == S_DONE);
      r_abort <= w_abort;
    end
  end

  assign isl_rd_o    = w_rd;
  assign isl_done_o  = r_done;
  assign isl_abort_o = r_abort;
  assign mode_o      = r_mode;
  assign ctl_o       = r_ctl;
  assign sync_o      = r_sync;
  assign rgb_o       = r_rgb;
  assign terc_o      = r_terc;

endmodule

// File: tb/tb_tmds_period_sched.sv
// Directed bench for tmds_period_sched: a scripted 7-line timing sequence is logged per
// cycle, then checked against hand-derived output cycles (output cycle = pixel + 11).
module tb_tmds_period_sched;
  localparam int N = 7000;

  logic        clk_i = 1'b0;
  logic        rst_i, de_i, hs_i, vs_i, isl_req_i;
  logic [23:0] rgb_i;
  logic [8:0]  isl_d_i;
  logic        isl_rd_o, isl_done_o, isl_abort_o;
  logic [2:0]  mode_o;
  logic [1:0]  sync_o;
  logic [3:0]  ctl_o;
  logic [23:0] rgb_o;
  logic [11:0] terc_o;

  int errors = 0;
  int checks = 0;

  logic [47:0] lg_all  [N];
  logic [2:0]  lg_mode [N];
  logic [3:0]  lg_ctl  [N];
  logic [1:0]  lg_sync [N];
  logic [23:0] lg_rgb  [N];
  logic [11:0] lg_terc [N];
  logic [N-1:0] lg_rd, lg_done, lg_abort;

  tmds_period_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .rgb_i(rgb_i),
    .isl_req_i(isl_req_i), .isl_d_i(isl_d_i), .isl_rd_o(isl_rd_o), .isl_done_o(isl_done_o),
    .isl_abort_o(isl_abort_o), .mode_o(mode_o), .sync_o(sync_o), .ctl_o(ctl_o),
    .rgb_o(rgb_o), .terc_o(terc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [23:0] pix(input int c);
    return 24'(c * 7919 + 3);
  endfunction

  function automatic logic [8:0] pat(input int c);
    return 9'(c * 37 + 5);
  endfunction

  function automatic int popc(input logic [N-1:0] v, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive pixel c's inputs mid-cycle, then log that cycle's outputs.
  task automatic step(input int c);
    @(negedge clk_i);
    rst_i     = (c == 5840);
    de_i      = (c >= 100 && c <= 739) || (c >= 1834 && c <= 1899);
    hs_i      = ((c % 1000) >= 800) && ((c % 1000) <= 831);
    vs_i      = (c >= 2000) && (c < 5000);
    isl_req_i = (c < 6820);
    rgb_i     = pix(c);
    isl_d_i   = pat(c);
    #1;
    lg_all[c]   = {mode_o, ctl_o, sync_o, rgb_o, terc_o, isl_rd_o, isl_done_o, isl_abort_o};
    lg_mode[c]  = mode_o;
    lg_ctl[c]   = ctl_o;
    lg_sync[c]  = sync_o;
    lg_rgb[c]   = rgb_o;
    lg_terc[c]  = terc_o;
    lg_rd[c]    = isl_rd_o;
    lg_done[c]  = isl_done_o;
    lg_abort[c] = isl_abort_o;
  endtask

  initial begin
    logic [8:0] p;
    rst_i = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; isl_req_i = 1'b0;
    rgb_i = '0; isl_d_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      rst_i = 1'b1; de_i = 1'($urandom); hs_i = 1'($urandom); vs_i = 1'($urandom);
      isl_req_i = 1'($urandom); rgb_i = 24'($urandom); isl_d_i = 9'($urandom);
    end
    for (int c = 0; c < N; c++) step(c);

    // reset: quiet outputs for 11 cycles after release
    for (int t = 0; t <= 10; t++) chk("rst_out", t, 64'(lg_all[t]), 64'd0);

    // active line: preamble, guard band, video
    chk("pre_vid_idle", 100, {lg_mode[100], lg_ctl[100]}, {3'd0, 4'b0000});
    for (int t = 101; t <= 108; t++) chk("vid_pre", t, {lg_mode[t], lg_ctl[t]}, {3'd0, 4'b0001});
    for (int t = 109; t <= 110; t++) chk("vid_gb", t, {lg_mode[t], lg_ctl[t]}, {3'd1, 4'b0000});
    for (int t = 111; t <= 750; t++) chk("video", t, {lg_mode[t], lg_rgb[t]}, {3'd2, pix(t - 11)});
    chk("vid_end", 751, {lg_mode[751], lg_ctl[751], lg_rgb[751]}, {3'd0, 4'b0000, 24'd0});
    chk("sync_pre", 810, 64'(lg_sync[810]), 64'(2'b00));
    chk("sync_edge", 811, 64'(lg_sync[811]), 64'(2'b01));
    chk("sync_last", 842, 64'(lg_sync[842]), 64'(2'b01));
    chk("sync_fall", 843, 64'(lg_sync[843]), 64'(2'b00));

    // island in horizontal blanking, hs edge at pixel 800
    chk("isl0_before", 814, {lg_mode[814], lg_ctl[814]}, {3'd0, 4'b0000});
    for (int t = 815; t <= 822; t++) chk("isl0_pre", t, {lg_mode[t], lg_ctl[t]}, {3'd0, 4'b0101});
    for (int t = 823; t <= 824; t++) chk("isl0_lgb", t, {lg_mode[t], lg_terc[t]}, {3'd3, 12'h00D});
    for (int t = 825; t <= 856; t++) begin
      p = pat(t - 1);
      chk("isl0_data", t, {lg_mode[t], lg_terc[t]},
          {3'd4, p[8:5], p[4:1], (t != 825), p[0], 1'b0, ((t - 11) <= 831)});
    end
    for (int t = 857; t <= 858; t++) chk("isl0_tgb", t, {lg_mode[t], lg_terc[t]}, {3'd3, 12'h00C});
    chk("isl0_done", 859, {lg_mode[859], lg_ctl[859], lg_terc[859], lg_done[859]}, {3'd0, 4'd0, 12'd0, 1'b1});
    chk("isl0_rd_first_m1", 823, 64'(lg_rd[823]), 64'd0);
    chk("isl0_rd_first", 824, 64'(lg_rd[824]), 64'd1);
    chk("isl0_rd_last", 855, 64'(lg_rd[855]), 64'd1);
    chk("isl0_rd_after", 856, 64'(lg_rd[856]), 64'd0);
    chk("isl0_rd_cnt", 0, 64'(popc(lg_rd, 0, 999)), 64'd32);
    chk("isl0_done_cnt", 0, 64'(popc(lg_done, 0, 999)), 64'd1);
    chk("isl0_abort_cnt", 0, 64'(popc(lg_abort, 0, 999)), 64'd0);

    // island cut short by de rising at pixel 1834
    chk("isl1_pre", 1815, {lg_mode[1815], lg_ctl[1815]}, {3'd0, 4'b0101});
    chk("isl1_data_last", 1834, 64'(lg_mode[1834]), 64'd4);
    chk("isl1_abort", 1835, 64'(lg_abort[1835]), 64'd1);
    for (int t = 1835; t <= 1842; t++) chk("isl1_vid_pre", t, {lg_mode[t], lg_ctl[t]}, {3'd0, 4'b0001});
    for (int t = 1843; t <= 1844; t++) chk("isl1_vid_gb", t, 64'(lg_mode[t]), 64'd1);
    chk("isl1_video", 1845, {lg_mode[1845], lg_rgb[1845]}, {3'd2, pix(1834)});
    chk("isl1_rd_last", 1833, 64'(lg_rd[1833]), 64'd1);
    chk("isl1_rd_drop", 1834, 64'(lg_rd[1834]), 64'd0);
    chk("isl1_rd_cnt", 1000, 64'(popc(lg_rd, 1000, 1999)), 64'd10);
    chk("isl1_abort_cnt", 1000, 64'(popc(lg_abort, 1000, 1999)), 64'd1);
    chk("isl1_done_cnt", 1000, 64'(popc(lg_done, 1000, 1999)), 64'd0);

    // vertical blanking: one island per line
    chk("vb_before", 2814, {lg_mode[2814], lg_ctl[2814]}, {3'd0, 4'b0000});
    chk("vb_pre", 2815, {lg_mode[2815], lg_ctl[2815], lg_sync[2815]}, {3'd0, 4'b0101, 2'b11});
    p = pat(2824);
    chk("vb_data0", 2825, {lg_mode[2825], lg_terc[2825]}, {3'd4, p[8:5], p[4:1], 1'b0, p[0], 2'b11});
    chk("vb_rd_cnt", 2000, 64'(popc(lg_rd, 2000, 4999)), 64'd96);
    chk("vb_done_cnt", 2000, 64'(popc(lg_done, 2000, 4999)), 64'd3);
    chk("vb_abort_cnt", 2000, 64'(popc(lg_abort, 2000, 4999)), 64'd0);

    // reset in the middle of DATA, then a clean island on the next line
    chk("rst_mid_data", 5840, 64'(lg_mode[5840]), 64'd4);
    chk("rst_mid_out", 5841, 64'(lg_all[5841]), 64'd0);
    chk("rst_mid_done", 5000, 64'(popc(lg_done, 5000, 5999)), 64'd0);
    chk("rst_mid_abort", 5000, 64'(popc(lg_abort, 5000, 5999)), 64'd0);
    chk("isl6_pre", 6815, {lg_mode[6815], lg_ctl[6815]}, {3'd0, 4'b0101});
    chk("isl6_data", 6825, 64'(lg_mode[6825]), 64'd4);
    chk("isl6_done", 6859, 64'(lg_done[6859]), 64'd1);
    chk("isl6_rd_cnt", 6000, 64'(popc(lg_rd, 6000, 6999)), 64'd32);
    chk("isl6_done_cnt", 6000, 64'(popc(lg_done, 6000, 6999)), 64'd1);
    chk("isl6_abort_cnt", 6000, 64'(popc(lg_abort, 6000, 6999)), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
